// File: rtl/mem_arb_pkg.sv
// Shared types for the SRAM arbiter: FSM state encoding and wait-counter width.
// Latency: n/a (type definitions only).
// Backpressure: n/a.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_DONE,
    ST_HOLD
  } state_t;

  // ACCESS-phase counter width; covers WAIT = 1..15.
  localparam int CNT_W = 4;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first requester scanning upward from rr+1, with optional ch0 override.
// Latency: purely combinational.
// Backpressure: none; valid simply reflects any request bit.
// Ports: req (per-channel request), rr (last granted channel), prio0 (ch0 wins when requesting),
//        g (picked channel), valid (some channel requesting).
module rr_pick
  import mem_arb_pkg::*;
#(
  parameter int CH = 4,
  parameter int RW = $clog2(CH)
) (
  input  logic [CH-1:0] req,
  input  logic [RW-1:0] rr,
  input  logic          prio0,
  output logic [RW-1:0] g,
  output logic          valid
);

  logic found;
  int   idx;

  always_comb begin
    g     = '0;
    found = 1'b0;
    idx   = 0;
    // Scan CH positions starting just after the last winner so every
    // requester is reached within CH grants.
    for (int i = 1; i <= CH; i++) begin
      idx = (int'(rr) + i) % CH;
      if (!found && req[idx]) begin
        g     = idx[RW-1:0];
        found = 1'b1;
      end
    end
    if (prio0 && req[0]) begin
      g = '0;
    end
    valid = |req;
  end

endmodule

// File: rtl/mem_arb.sv
// Arbitrates CH requesters onto one asynchronous 16-bit SRAM with setup/access/done(/hold) phases.
// Latency: ack pulses WAIT+2 cycles after the grant cycle; next grant WAIT+3 (read) or WAIT+4 (write).
// Backpressure: requests are level-held until ack; busy is high whenever the port is not IDLE.
// Ports: req/we_lo/we_hi/addr/wdata per channel in, ack per channel out, rdata/busy out,
//        ram_* drive the SRAM pins (controls active-low), ram_di is the SRAM read data.
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int CH    = 4,
  parameter int AW    = 22,
  parameter int DW    = 16,
  parameter int WAIT  = 2,
  parameter bit PRIO0 = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CH-1:0]    req,
  input  logic [CH-1:0]    we_lo,
  input  logic [CH-1:0]    we_hi,
  input  logic [CH*AW-1:0] addr,
  input  logic [CH*DW-1:0] wdata,
  output logic [CH-1:0]    ack,
  output logic [DW-1:0]    rdata,
  output logic             busy,
  output logic [AW-1:0]    ram_addr,
  output logic [DW-1:0]    ram_do,
  output logic             ram_dir,
  input  logic [DW-1:0]    ram_di,
  output logic             ram_ce,
  output logic             ram_oe,
  output logic             ram_we,
  output logic             ram_ub,
  output logic             ram_lb
);

  localparam int RW = $clog2(CH);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [RW-1:0]    rr;
  logic [RW-1:0]    g_q;
  logic             is_wr;
  logic [RW-1:0]    pick_g;
  logic             pick_vld;
  logic             sel_lo;
  logic             sel_hi;

  rr_pick #(
    .CH (CH),
    .RW (RW)
  ) u_pick (
    .req   (req),
    .rr    (rr),
    .prio0 (PRIO0),
    .g     (pick_g),
    .valid (pick_vld)
  );

  assign sel_lo = we_lo[pick_g];
  assign sel_hi = we_hi[pick_g];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      rr       <= RW'(CH - 1);
      g_q      <= '0;
      is_wr    <= 1'b0;
      ack      <= '0;
      rdata    <= '0;
      busy     <= 1'b0;
      ram_addr <= '0;
      ram_do   <= '0;
      ram_dir  <= 1'b0;
      ram_ce   <= 1'b1;
      ram_oe   <= 1'b1;
      ram_we   <= 1'b1;
      ram_ub   <= 1'b1;
      ram_lb   <= 1'b1;
    end else begin
      ack <= '0;
      case (state)
        ST_IDLE: begin
          if (pick_vld) begin
            g_q      <= pick_g;
            rr       <= pick_g;
            is_wr    <= sel_lo | sel_hi;
            ram_addr <= addr[pick_g*AW +: AW];
            ram_do   <= wdata[pick_g*DW +: DW];
            ram_ce   <= 1'b0;
            // Reads enable both lanes; writes enable only the strobed lanes.
            ram_ub   <= (sel_lo | sel_hi) ? !sel_hi : 1'b0;
            ram_lb   <= (sel_lo | sel_hi) ? !sel_lo : 1'b0;
            ram_dir  <= sel_lo | sel_hi;
            busy     <= 1'b1;
            state    <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          cnt <= CNT_W'(WAIT - 1);
          if (is_wr) ram_we <= 1'b0;
          else       ram_oe <= 1'b0;
          state <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (cnt == '0) begin
            ram_oe     <= 1'b1;
            ram_we     <= 1'b1;
            ack[g_q]   <= 1'b1;
            if (!is_wr) begin
              rdata  <= ram_di;
              ram_ce <= 1'b1;
              ram_ub <= 1'b1;
              ram_lb <= 1'b1;
            end
            state <= ST_DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_DONE: begin
          if (is_wr) begin
            // Deselect first, keep data driven one more cycle for SRAM hold time.
            ram_ce <= 1'b1;
            ram_ub <= 1'b1;
            ram_lb <= 1'b1;
            state  <= ST_HOLD;
          end else begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        ST_HOLD: begin
          ram_dir <= 1'b0;
          busy    <= 1'b0;
          state   <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
